// File: rtl/uart_pkt_pkg.sv
`default_nettype none
// =============================================================================
// Module : uart_pkt_pkg
// Purpose: Definitions shared by the UART sample packetizer: the packet sync
//          byte, the framing FSM state encoding, and a helper that returns the
//          packet length in bytes.
// Ports  : none (package)
// Rev    : 1.0  initial release
// =============================================================================
package uart_pkt_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SYNC    = 3'd1,
      ST_SEQ     = 3'd2,
      ST_DATA    = 3'd3,
      ST_CSUM    = 3'd4,
      ST_GUARD   = 3'd5,
      ST_WAITRDY = 3'd6
   } pkt_state_e;

   // Sync + sequence + payload bytes, plus one checksum byte when enabled.
   function automatic int bytes_per_pkt(input int sample_w,
                                        input int samples_per_pkt,
                                        input bit csum_en);
      return 2 + samples_per_pkt * (sample_w / 8) + (csum_en ? 1 : 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sample_packetizer_sample_fifo.sv
`default_nettype none
// =============================================================================
// Module : sample_fifo
// Purpose: Synchronous FIFO with a registered occupancy count. The read port
//          is fall-through: rd_data always shows the oldest entry.
// Ports  : clk, reset_b (async, active-low)
//          push / wr_data  - write request (ignored while full)
//          pop  / rd_data  - read request (ignored while empty)
//          count           - entries held (registered)
//          full, empty     - decoded from count
// Rev    : 1.0  initial release
// =============================================================================
module sample_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q,  count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == FULL_COUNT);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers are exactly AW bits so they wrap at DEPTH without extra logic.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/uart_sample_packetizer.sv
`default_nettype none
// =============================================================================
// Module : uart_sample_packetizer
// Purpose: Buffers samples and frames groups of SAMPLES_PER_PKT of them into
//          byte packets (sync, sequence, payload MSB-first, optional checksum)
//          paced to a UART transmitter via tx_ready / tx_write_en.
// Ports  : clk, reset_b (async, active-low)
//          sample_in/sample_valid/sample_ready - sample stream into the FIFO
//          tx_ready/tx_data/tx_write_en        - byte handshake to the UART
//          busy       - packet in progress
//          fifo_count - samples buffered
//          overflow   - sticky, a sample arrived while the FIFO was full
// Config : define UART_PKT_CHECKSUM_EN to append an XOR checksum byte
//          (sequence byte and payload bytes; sync byte excluded).
// Rev    : 1.0  initial release
// =============================================================================
module uart_sample_packetizer
   import uart_pkt_pkg::*;
#(
   parameter int SAMPLE_W        = 16,
   parameter int SAMPLES_PER_PKT = 4,
   parameter int FIFO_DEPTH      = 16,
   parameter int FIFO_AW         = 4,
   parameter int GUARD_CYCLES    = 4
) (
   input  logic                clk,
   input  logic                reset_b,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   output logic                sample_ready,
   input  logic                tx_ready,
   output logic [7:0]          tx_data,
   output logic                tx_write_en,
   output logic                busy,
   output logic [FIFO_AW:0]    fifo_count,
   output logic                overflow
);

   localparam int                BYTES_PER_SAMPLE = SAMPLE_W / 8;
   localparam int                GUARD_W     = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);
   localparam logic [7:0]        BYTE_LAST   = 8'(BYTES_PER_SAMPLE - 1);
   localparam logic [7:0]        SAMPLE_LAST = 8'(SAMPLES_PER_PKT - 1);
   localparam logic [FIFO_AW:0]  PKT_THRESH  = (FIFO_AW+1)'(SAMPLES_PER_PKT);

   logic [SAMPLE_W-1:0] fifo_rd_data;
   logic                fifo_full, fifo_empty, fifo_pop;

   pkt_state_e          state_q, state_d, ret_state_q, ret_state_d;
   logic                last_q, last_d;
   logic [GUARD_W-1:0]  guard_cnt_q, guard_cnt_d;
   logic [7:0]          byte_idx_q, byte_idx_d;
   logic [7:0]          sample_idx_q, sample_idx_d;
   logic [SAMPLE_W-1:0] shreg_q, shreg_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                tx_write_en_q, tx_write_en_d;
   logic                busy_q, busy_d;
   logic [7:0]          seq_q, seq_d;
   logic                overflow_q, overflow_d;
`ifdef UART_PKT_CHECKSUM_EN
   logic [7:0]          csum_q, csum_d;
`endif

   // Per-state byte selection feeding the common issue logic.
   logic                emit;
   logic [7:0]          byte_out;
   pkt_state_e          nxt_state;
   logic                nxt_last;
   logic                last_byte, last_sample;

   sample_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .reset_b (reset_b),
      .push    (sample_valid),
      .wr_data (sample_in),
      .pop     (fifo_pop),
      .rd_data (fifo_rd_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign sample_ready = !fifo_full;
   assign tx_data      = tx_data_q;
   assign tx_write_en  = tx_write_en_q;
   assign busy         = busy_q;
   assign overflow     = overflow_q;

   always_comb begin
      state_d       = state_q;
      ret_state_d   = ret_state_q;
      last_d        = last_q;
      guard_cnt_d   = guard_cnt_q;
      byte_idx_d    = byte_idx_q;
      sample_idx_d  = sample_idx_q;
      shreg_d       = shreg_q;
      tx_data_d     = tx_data_q;
      tx_write_en_d = 1'b0;
      busy_d        = busy_q;
      seq_d         = seq_q;
      overflow_d    = overflow_q | (sample_valid & fifo_full);
`ifdef UART_PKT_CHECKSUM_EN
      csum_d        = csum_q;
`endif
      emit          = 1'b0;
      byte_out      = tx_data_q;
      nxt_state     = ST_IDLE;
      nxt_last      = 1'b0;
      last_byte     = (byte_idx_q == BYTE_LAST);
      last_sample   = (sample_idx_q == SAMPLE_LAST);
      fifo_pop      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (fifo_count >= PKT_THRESH) begin
               state_d = ST_SYNC;
               busy_d  = 1'b1;
            end
         end
         ST_SYNC: begin
            emit         = 1'b1;
            byte_out     = SYNC_BYTE;
            nxt_state    = ST_SEQ;
            byte_idx_d   = '0;
            sample_idx_d = '0;
`ifdef UART_PKT_CHECKSUM_EN
            csum_d       = '0;
`endif
         end
         ST_SEQ: begin
            emit      = 1'b1;
            byte_out  = seq_q;
            nxt_state = ST_DATA;
         end
         ST_DATA: begin
            emit = 1'b1;
            // First byte of a sample comes straight from the FIFO head; the
            // rest are shifted out of the holding register.
            byte_out = (byte_idx_q == 8'd0) ? fifo_rd_data[SAMPLE_W-1 -: 8]
                                            : shreg_q[SAMPLE_W-1 -: 8];
            if (last_byte && last_sample) begin
`ifdef UART_PKT_CHECKSUM_EN
               nxt_state = ST_CSUM;
`else
               nxt_last  = 1'b1;
`endif
            end else begin
               nxt_state = ST_DATA;
            end
            if (tx_ready) begin
               if (byte_idx_q == 8'd0) begin
                  fifo_pop = !fifo_empty;
                  shreg_d  = fifo_rd_data << 8;
               end else begin
                  shreg_d  = shreg_q << 8;
               end
               if (last_byte) begin
                  byte_idx_d   = '0;
                  sample_idx_d = sample_idx_q + 8'd1;
               end else begin
                  byte_idx_d   = byte_idx_q + 8'd1;
               end
            end
         end
`ifdef UART_PKT_CHECKSUM_EN
         ST_CSUM: begin
            emit     = 1'b1;
            byte_out = csum_q;
            nxt_last = 1'b1;
         end
`endif
         ST_GUARD: begin
            if (guard_cnt_q == GUARD_LAST) begin
               if (last_q) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  seq_d   = seq_q + 8'd1;
               end else begin
                  state_d = ST_WAITRDY;
               end
            end else begin
               guard_cnt_d = guard_cnt_q + 1'b1;
            end
         end
         ST_WAITRDY: begin
            if (tx_ready) state_d = ret_state_q;
         end
         default: state_d = ST_IDLE;
      endcase

      // Common byte issue: register the byte, strobe once, enter the guard.
      if (emit && tx_ready) begin
         tx_data_d     = byte_out;
         tx_write_en_d = 1'b1;
         state_d       = ST_GUARD;
         guard_cnt_d   = '0;
         ret_state_d   = nxt_state;
         last_d        = nxt_last;
`ifdef UART_PKT_CHECKSUM_EN
         if (state_q == ST_SEQ || state_q == ST_DATA) csum_d = csum_q ^ byte_out;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q       <= ST_IDLE;
         ret_state_q   <= ST_IDLE;
         last_q        <= 1'b0;
         guard_cnt_q   <= '0;
         byte_idx_q    <= '0;
         sample_idx_q  <= '0;
         shreg_q       <= '0;
         tx_data_q     <= 8'h00;
         tx_write_en_q <= 1'b0;
         busy_q        <= 1'b0;
         seq_q         <= 8'h00;
         overflow_q    <= 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
         csum_q        <= 8'h00;
`endif
      end else begin
         state_q       <= state_d;
         ret_state_q   <= ret_state_d;
         last_q        <= last_d;
         guard_cnt_q   <= guard_cnt_d;
         byte_idx_q    <= byte_idx_d;
         sample_idx_q  <= sample_idx_d;
         shreg_q       <= shreg_d;
         tx_data_q     <= tx_data_d;
         tx_write_en_q <= tx_write_en_d;
         busy_q        <= busy_d;
         seq_q         <= seq_d;
         overflow_q    <= overflow_d;
`ifdef UART_PKT_CHECKSUM_EN
         csum_q        <= csum_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_sample_packetizer.sv
`default_nettype none
// =============================================================================
// Module : tb_uart_sample_packetizer
// Purpose: Directed self-checking bench for uart_sample_packetizer with the
//          default parameters (16-bit samples, 4 per packet, 16-deep FIFO,
//          4 guard cycles). Honours UART_PKT_CHECKSUM_EN when defined.
// Rev    : 1.0  initial release
// =============================================================================
module tb_uart_sample_packetizer;
   import uart_pkt_pkg::*;

`ifdef UART_PKT_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif
   localparam int PKT_BYTES = bytes_per_pkt(16, 4, CSUM_EN);
   localparam int GAP       = 6;   // guard cycles + 2

   logic        clk;
   logic        reset_b;
   logic [15:0] sample_in;
   logic        sample_valid;
   logic        sample_ready;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic        tx_write_en;
   logic        busy;
   logic [4:0]  fifo_count;
   logic        overflow;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [15:0] samp [4];

   uart_sample_packetizer dut (
      .clk          (clk),
      .reset_b      (reset_b),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .tx_ready     (tx_ready),
      .tx_data      (tx_data),
      .tx_write_en  (tx_write_en),
      .busy         (busy),
      .fifo_count   (fifo_count),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog observed no finish required finish within 100000 cycles");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected byte i of a packet built from samp[] with sequence byte seq.
   function automatic logic [7:0] exp_byte(input logic [7:0] seq, input int i);
      logic [7:0] x;
      if (i == 0) return 8'hA5;
      if (i == 1) return seq;
      if (i < 10) return ((i % 2) == 0) ? samp[(i-2)/2][15:8] : samp[(i-2)/2][7:0];
      x = seq;
      for (int j = 0; j < 4; j++) x = x ^ samp[j][15:8] ^ samp[j][7:0];
      return x;
   endfunction

   // Called at a falling edge; returns at the falling edge after the push edge.
   task automatic push_sample(input logic [15:0] d);
      sample_in    = d;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] exp,
                              input int budget, output int at);
      at = -1;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (tx_write_en === 1'b1) begin
            at = cyc;
            break;
         end
      end
      chk({tag, "_strobe"}, (at >= 0), 1);
      if (at >= 0) chk(tag, tx_data, exp);
   endtask

   task automatic expect_quiet(input string tag, input int ncyc);
      int n = 0;
      repeat (ncyc) begin
         @(negedge clk);
         if (tx_write_en !== 1'b0) n++;
      end
      chk(tag, n, 0);
   endtask

   task automatic wait_idle(input string tag);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (busy === 1'b0) break;
      end
      chk({tag, "_busy_clear"}, busy, 0);
      chk({tag, "_fifo_empty"}, fifo_count, 0);
   endtask

   // Push samples first..3 of samp[], then check every byte and its timing.
   task automatic run_packet(input logic [7:0] seq, input int first);
      int t0, at, prev;
      for (int k = first; k < 4; k++) push_sample(samp[k]);
      t0   = cyc;
      prev = t0;
      for (int i = 0; i < PKT_BYTES; i++) begin
         expect_byte($sformatf("seq%02h_byte%0d", seq, i), exp_byte(seq, i), 30, at);
         chk($sformatf("seq%02h_gap%0d", seq, i), at - prev, (i == 0) ? 2 : GAP);
         prev = at;
      end
      wait_idle($sformatf("seq%02h", seq));
   endtask

   initial begin
      int t0, at, prev;
      samp[0] = 16'h1234; samp[1] = 16'h5678; samp[2] = 16'h9ABC; samp[3] = 16'hDEF0;
      reset_b      = 1'b0;
      sample_in    = '0;
      sample_valid = 1'b0;
      tx_ready     = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_tx_data",      tx_data,      8'h00);
      chk("rst_tx_write_en",  tx_write_en,  0);
      chk("rst_busy",         busy,         0);
      chk("rst_overflow",     overflow,     0);
      chk("rst_fifo_count",   fifo_count,   0);
      chk("rst_sample_ready", sample_ready, 1);
      reset_b = 1'b1;
      @(negedge clk);

      // Single packet, tx_ready held high
      tx_ready = 1'b1;
      run_packet(8'h00, 0);

      // Backpressure after the third strobe
      for (int k = 0; k < 4; k++) push_sample(samp[k]);
      t0 = cyc;
      prev = t0;
      for (int i = 0; i < 3; i++) begin
         expect_byte($sformatf("bp_byte%0d", i), exp_byte(8'h01, i), 30, at);
         chk($sformatf("bp_gap%0d", i), at - prev, (i == 0) ? 2 : GAP);
         prev = at;
      end
      tx_ready = 1'b0;
      expect_quiet("bp_quiet", 20);
      chk("bp_busy_held", busy, 1);
      tx_ready = 1'b1;
      prev = cyc;
      for (int i = 3; i < PKT_BYTES; i++) begin
         expect_byte($sformatf("bp_byte%0d", i), exp_byte(8'h01, i), 30, at);
         chk($sformatf("bp_gap%0d", i), at - prev, (i == 3) ? 2 : GAP);
         prev = at;
      end
      wait_idle("bp");

      // Partial fill: three samples must not start a packet
      for (int k = 0; k < 3; k++) push_sample(samp[k]);
      expect_quiet("partial_quiet", 10);
      chk("partial_busy",  busy,       0);
      chk("partial_count", fifo_count, 3);
      run_packet(8'h02, 3);

      // Sequence counter through FF and wrap back to 00
      for (int p = 3; p <= 256; p++) run_packet(8'(p), 0);

      // Overflow with the transmitter stalled
      tx_ready = 1'b0;
      for (int k = 0; k < 16; k++) push_sample(16'hC000 + 16'(k));
      chk("ovf_count16",      fifo_count,   16);
      chk("ovf_ready_low",    sample_ready, 0);
      chk("ovf_not_yet",      overflow,     0);
      push_sample(16'hBEEF);
      chk("ovf_set",          overflow,     1);
      chk("ovf_count_held",   fifo_count,   16);
      repeat (3) @(negedge clk);
      chk("ovf_sticky",       overflow,     1);

      // Reset in the middle of a packet, after its fifth byte
      tx_ready = 1'b1;
      expect_byte("mid_byte0", 8'hA5, 30, at);
      expect_byte("mid_byte1", 8'h01, 30, at);
      expect_byte("mid_byte2", 8'hC0, 30, at);
      expect_byte("mid_byte3", 8'h00, 30, at);
      expect_byte("mid_byte4", 8'hC0, 30, at);
      reset_b = 1'b0;
      #1;
      chk("mid_rst_tx_data",      tx_data,      8'h00);
      chk("mid_rst_tx_write_en",  tx_write_en,  0);
      chk("mid_rst_busy",         busy,         0);
      chk("mid_rst_overflow",     overflow,     0);
      chk("mid_rst_fifo_count",   fifo_count,   0);
      chk("mid_rst_sample_ready", sample_ready, 1);
      @(negedge clk);
      @(negedge clk);
      reset_b = 1'b1;
      expect_quiet("post_rst_quiet", 10);
      chk("post_rst_busy", busy, 0);
      run_packet(8'h00, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
